// File: rtl/stream_fifo_pkg.sv
// ---------------------------------------------------------------------------
// stream_fifo_pkg
//   Shared configuration for the stream FIFO slice.
//   Provides the default geometry (depth and data width) picked up by
//   stream_fifo, plus a small helper used by its elaboration-time checks.
//   No ports: this is a package.
// ---------------------------------------------------------------------------
package stream_fifo_pkg;

    // Default number of entries; must stay a power of two, at least 2.
    localparam int CFG_DEPTH  = 8;

    // Default data word width in bits.
    localparam int CFG_DWIDTH = 16;

    // True when v is a power of two and at least 2, which the pointer
    // scheme relies on so the low pointer bits index storage directly.
    function automatic bit is_legal_depth(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage : stream_fifo_pkg

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//   Single-clock synchronous FIFO with show-ahead output, occupancy and
//   threshold flags, sticky overflow/underflow error flags and a
//   synchronous flush.
//
// Parameters
//   DEPTH    : number of entries (power of two, >= 2)
//   DWIDTH   : data word width
//   AF_LEVEL : almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL : almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : empty the FIFO at the next edge (beats wr/rd)
//   wr_en, din        : write request and data
//   rd_en             : pop request
//   dout              : head-of-queue data, valid whenever !empty
//   empty, full       : occupancy status
//   almost_empty/full : threshold status
//   count             : stored entries, 0..DEPTH
//   overflow          : sticky, write refused because full
//   underflow         : sticky, read attempted while empty
//   err_clr           : clear both sticky error flags
// ---------------------------------------------------------------------------
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DEPTH    = CFG_DEPTH,
    parameter int DWIDTH   = CFG_DWIDTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DWIDTH-1:0]          din,
    input  logic                       rd_en,
    output logic [DWIDTH-1:0]          dout,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    // Reject geometries the pointer arithmetic and flag logic cannot honour.
    if (!is_legal_depth(DEPTH)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af_level
        $error("stream_fifo: AF_LEVEL must lie in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae_level
        $error("stream_fifo: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              empty_w;
    logic              full_w;
    logic [PW-1:0]     count_w;
    logic              wr_accept;
    logic              rd_accept;

    // Status decode. The extra pointer MSB tells a full buffer (MSBs
    // differ, indices equal) apart from an empty one (pointers equal);
    // the subtraction wraps naturally modulo 2*DEPTH.
    always_comb begin
        empty_w = (wptr_q == rptr_q);
        full_w  = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        count_w = wptr_q - rptr_q;
    end

    // A write into a full FIFO is allowed only when a pop frees a slot
    // on the same edge. A read on empty is never paired with the write
    // of that cycle (no bypass), so the new word becomes visible next cycle.
    always_comb begin
        wr_accept = wr_en && (!full_w || rd_en) && !flush;
        rd_accept = rd_en && !empty_w && !flush;
    end

    // Next-state for pointers and storage. Flush rewinds both pointers
    // but leaves storage alone, so stale words may sit behind an empty FIFO.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_accept) begin
                wptr_d = wptr_q + PW'(1);
                mem_d[wptr_q[AW-1:0]] = din;
            end
            if (rd_accept) begin
                rptr_d = rptr_q + PW'(1);
            end
        end
    end

    // Sticky error flags: err_clr clears them, but a fresh error in the
    // same cycle must not be lost, so the set terms are applied last.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_w && !rd_en && !flush) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_w && !flush) begin
            underflow_d = 1'b1;
        end
    end

    // State registers. Reset clears storage too so dout reads zero
    // straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mem_q       <= mem_d;
        end
    end

    // Outputs follow the registered pointers with no extra latency.
    always_comb begin
        dout         = mem_q[rptr_q[AW-1:0]];
        empty        = empty_w;
        full         = full_w;
        count        = count_w;
        almost_full  = (count_w >= AF_THRESH);
        almost_empty = (count_w <= AE_THRESH);
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule : stream_fifo

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//   Self-checking bench for stream_fifo (DEPTH=8, DWIDTH=16, AF=6, AE=1).
//   A table of hand-computed vectors covers fill, full simultaneous access,
//   overflow, drain, underflow and error clear; hand sequences cover
//   wrap, flush priority, err_clr vs. a new error and asynchronous reset;
//   a randomized phase is checked against a queue-based model.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

    localparam int DEPTH  = 8;
    localparam int DWIDTH = 16;
    localparam int AF     = 6;
    localparam int AE     = 1;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              wr_en;
    logic [DWIDTH-1:0] din;
    logic              rd_en;
    logic [DWIDTH-1:0] dout;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    int tests = 0;
    int fails = 0;

    // Reference model: the stored words in arrival order plus the two flags.
    logic [DWIDTH-1:0] mq[$];
    logic              m_ov;
    logic              m_un;

    typedef struct {
        logic              f;
        logic              w;
        logic              r;
        logic              c;
        logic [DWIDTH-1:0] d;
        int                ecount;
        logic              eempty;
        logic              efull;
        logic              eae;
        logic              eaf;
        logic              eov;
        logic              eun;
        logic              dv;
        logic [DWIDTH-1:0] edout;
    } vec_t;

    vec_t vecs[$];

    stream_fifo #(
        .DEPTH    (DEPTH),
        .DWIDTH   (DWIDTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Applies the queue-semantics rules for one clock edge.
    task automatic modelStep(input logic f, input logic w, input logic r,
                             input logic c, input logic [DWIDTH-1:0] d);
        int  n;
        bit  mfull;
        bit  mempty;
        n      = mq.size();
        mfull  = (n == DEPTH);
        mempty = (n == 0);
        if (c) begin
            m_ov = 1'b0;
            m_un = 1'b0;
        end
        if (w && mfull && !r && !f) m_ov = 1'b1;
        if (r && mempty && !f)      m_un = 1'b1;
        if (f) begin
            mq.delete();
        end else begin
            if (r && !mempty)        void'(mq.pop_front());
            if (w && (!mfull || r))  mq.push_back(d);
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge and
    // returns at the following falling edge, ready for sampling.
    task automatic applyStimulus(input logic f, input logic w, input logic r,
                                 input logic c, input logic [DWIDTH-1:0] d);
        flush   = f;
        wr_en   = w;
        rd_en   = r;
        err_clr = c;
        din     = d;
        @(posedge clk);
        modelStep(f, w, r, c, d);
        @(negedge clk);
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    // Compares every output against the reference model.
    task automatic checkOutput(input string tag);
        int n;
        n = mq.size();
        checkVal({tag, "_count"},  32'(count),        32'(n));
        checkVal({tag, "_empty"},  32'(empty),        32'(n == 0));
        checkVal({tag, "_full"},   32'(full),         32'(n == DEPTH));
        checkVal({tag, "_ae"},     32'(almost_empty), 32'(n <= AE));
        checkVal({tag, "_af"},     32'(almost_full),  32'(n >= AF));
        checkVal({tag, "_ovf"},    32'(overflow),     32'(m_ov));
        checkVal({tag, "_unf"},    32'(underflow),    32'(m_un));
        if (n > 0) checkVal({tag, "_dout"}, 32'(dout), 32'(mq[0]));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_count"}, 32'(count),        32'd0);
        checkVal({tag, "_empty"}, 32'(empty),        32'd1);
        checkVal({tag, "_full"},  32'(full),         32'd0);
        checkVal({tag, "_ae"},    32'(almost_empty), 32'd1);
        checkVal({tag, "_af"},    32'(almost_full),  32'd0);
        checkVal({tag, "_ovf"},   32'(overflow),     32'd0);
        checkVal({tag, "_unf"},   32'(underflow),    32'd0);
        checkVal({tag, "_dout"},  32'(dout),         32'd0);
    endtask

    function automatic vec_t mkVec(input logic f, input logic w, input logic r, input logic c,
                                   input int d, input int ec, input logic eov, input logic eun,
                                   input int edout);
        vec_t v;
        v.f      = f;
        v.w      = w;
        v.r      = r;
        v.c      = c;
        v.d      = DWIDTH'(d);
        v.ecount = ec;
        v.eempty = (ec == 0);
        v.efull  = (ec == DEPTH);
        v.eae    = (ec <= AE);
        v.eaf    = (ec >= AF);
        v.eov    = eov;
        v.eun    = eun;
        v.dv     = (ec != 0);
        v.edout  = DWIDTH'(edout);
        return v;
    endfunction

    initial begin
        logic [DWIDTH-1:0] expect_q[$];
        logic              ov_before;
        logic              un_before;

        rst     = 1'b1;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        din     = '0;
        mq.delete();
        m_ov    = 1'b0;
        m_un    = 1'b0;

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // Table: fill, full wr+rd, overflow, drain, underflow, recovery.
        for (int i = 1; i <= DEPTH; i++)
            vecs.push_back(mkVec(0, 1, 0, 0, i, i, 0, 0, 1));
        vecs.push_back(mkVec(0, 1, 1, 0, 9, 8, 0, 0, 2));
        vecs.push_back(mkVec(0, 1, 0, 0, 'hA, 8, 1, 0, 2));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mkVec(0, 0, 1, 0, 0, 8 - i, 1, 0, 2 + i));
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 'h55, 1, 1, 1, 'h55));
        vecs.push_back(mkVec(0, 0, 0, 1, 0, 1, 0, 0, 'h55));
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].d);
            checkVal($sformatf("vec%0d_count", i), 32'(count),        32'(vecs[i].ecount));
            checkVal($sformatf("vec%0d_empty", i), 32'(empty),        32'(vecs[i].eempty));
            checkVal($sformatf("vec%0d_full", i),  32'(full),         32'(vecs[i].efull));
            checkVal($sformatf("vec%0d_ae", i),    32'(almost_empty), 32'(vecs[i].eae));
            checkVal($sformatf("vec%0d_af", i),    32'(almost_full),  32'(vecs[i].eaf));
            checkVal($sformatf("vec%0d_ovf", i),   32'(overflow),     32'(vecs[i].eov));
            checkVal($sformatf("vec%0d_unf", i),   32'(underflow),    32'(vecs[i].eun));
            if (vecs[i].dv)
                checkVal($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].edout));
        end

        // Interleaved traffic across pointer wrap; popped order must match pushes.
        expect_q.delete();
        for (int k = 0; k < 20; k++) begin
            logic              w;
            logic              r;
            logic [DWIDTH-1:0] d;
            w = (k % 3) != 2;
            r = (k % 2) == 1;
            d = DWIDTH'(16'h1000 + k);
            if (r && (count != 0)) begin
                checkVal($sformatf("wrap%0d_order", k), 32'(dout),
                         (expect_q.size() > 0) ? 32'(expect_q[0]) : 32'hFFFF_FFFF);
                if (expect_q.size() > 0) void'(expect_q.pop_front());
            end
            if (w && (count != CW'(DEPTH) || r)) expect_q.push_back(d);
            applyStimulus(1'b0, w, r, 1'b0, d);
            checkOutput($sformatf("wrap%0d", k));
        end

        // Flush priority with count=5 and underflow already set.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, DWIDTH'(16'h2000 + k));
        checkVal("pre_flush_count", 32'(count), 32'd5);
        ov_before = m_ov;
        un_before = m_un;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF);
        checkVal("flush_count", 32'(count),        32'd0);
        checkVal("flush_empty", 32'(empty),        32'd1);
        checkVal("flush_ae",    32'(almost_empty), 32'd1);
        checkVal("flush_ovf",   32'(overflow),     32'(ov_before));
        checkVal("flush_unf",   32'(underflow),    32'd1);
        checkOutput("flush");

        // err_clr together with a fresh read on empty: the new error wins.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
        checkVal("errclr_unf_wins", 32'(underflow), 32'd1);
        checkOutput("errclr");

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic f;
            logic w;
            logic r;
            logic c;
            f = ($urandom_range(0, 31) == 0);
            c = ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            applyStimulus(f, w, r, c, DWIDTH'($urandom));
            checkOutput($sformatf("rand%0d", k));
        end

        // Asynchronous reset mid-fill with an error flag set.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, DWIDTH'(16'h3000 + k));
        checkVal("prerst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async_rst");
        wr_en = 1'b1;
        din   = 16'h4444;
        rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst_hold");
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h5A5A);
        checkVal("post_rst_dout", 32'(dout), 32'h5A5A);
        checkOutput("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_stream_fifo
